// File: rtl/spi_slave_sync.sv
// spi_slave_sync: SPI mode-0 slave that oversamples sclk/cs/mosi in the clk domain.
// Config macro: SPI_SLV_MSB_FIRST_EN. When it is defined, both directions are MSB-first.
// When it is undefined (the default), both directions are LSB-first.
// Ports:
//   clk, rst         system clock; synchronous active-low reset
//   sclk, cs, mosi   raw SPI bus from the master, asynchronous to clk
//   miso             slave-out data
//   tx_data, tx_load response word and its 1-cycle load strobe into the tx shadow
//   rx_data          last complete received word
//   rx_valid, err    1-cycle pulses: frame complete / frame aborted
//   busy             high while the FSM is not IDLE
module spi_slave_sync #(
    parameter int DW          = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          cs,
    input  logic          mosi,
    output logic          miso,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_load,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    output logic          err,
    output logic          busy
);
    localparam int CW = $clog2(DW + 1);
    localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, WAIT_CS = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
    logic sclk_d, cs_d, mosi_d;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] shadow, tx_sh, rx_sh, tx_first, tx_next, rx_next;
    logic miso_first, miso_next;

    assign busy = (state != IDLE);

    // The synchronizers reset to the bus idle levels, so releasing reset never produces a false edge.
    // The edge events are registered, which puts each one SYNC_STAGES+1 clk after the raw edge.
    // mosi_d is delayed the same way as the edge events, so it lines up with them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_q    <= '0;
            cs_q      <= '1;
            mosi_q    <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            mosi_d    <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[SYNC_STAGES-2:0], sclk};
            cs_q      <= {cs_q[SYNC_STAGES-2:0], cs};
            mosi_q    <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_q[SYNC_STAGES-1];
            cs_d      <= cs_q[SYNC_STAGES-1];
            mosi_d    <= mosi_q[SYNC_STAGES-1];
            sclk_rise <= sclk_q[SYNC_STAGES-1] & ~sclk_d;
            sclk_fall <= ~sclk_q[SYNC_STAGES-1] & sclk_d;
            cs_fall   <= ~cs_q[SYNC_STAGES-1] & cs_d;
            cs_rise   <= cs_q[SYNC_STAGES-1] & ~cs_d;
        end
    end

    // A tx_load that lands in the same cycle as the cs fall bypasses the shadow register.
    always_comb begin
        tx_first = tx_load ? tx_data : shadow;
`ifdef SPI_SLV_MSB_FIRST_EN
        rx_next    = {rx_sh[DW-2:0], mosi_d};
        tx_next    = tx_sh << 1;
        miso_first = tx_first[DW-1];
        miso_next  = tx_sh[DW-2];
`else
        rx_next    = {mosi_d, rx_sh[DW-1:1]};
        tx_next    = tx_sh >> 1;
        miso_first = tx_first[0];
        miso_next  = tx_sh[1];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shadow   <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            err      <= 1'b0;
            miso     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            err      <= 1'b0;
            if (tx_load)
                shadow <= tx_data;
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall) begin
                        tx_sh <= tx_first;
                        miso  <= miso_first;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == CW'(DW)) begin
                        // The frame is complete. A cs rise in this same cycle just skips WAIT_CS.
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                        state    <= cs_rise ? IDLE : WAIT_CS;
                        miso     <= cs_rise ? 1'b0 : miso;
                    end else if (cs_rise) begin
                        // cs rise wins over sclk. The exception is a final rise that arrives with it, which still completes the frame.
                        state <= IDLE;
                        miso  <= 1'b0;
                        if (sclk_rise && cnt == CW'(DW - 1)) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        if (sclk_rise) begin
                            rx_sh <= rx_next;
                            cnt   <= cnt + 1'b1;
                        end
                        if (sclk_fall) begin
                            tx_sh <= tx_next;
                            miso  <= miso_next;
                        end
                    end
                end
                WAIT_CS: begin
                    if (cs_rise) begin
                        state <= IDLE;
                        miso  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: directed self-checking bench for spi_slave_sync (default LSB-first build).
module tb_spi_slave_sync;
    logic        clk = 1'b0, rst = 1'b0, sclk = 1'b0, cs = 1'b0, mosi = 1'b0, tx_load = 1'b0;
    logic [11:0] tx_data = '0, rx_data, r;
    logic        miso, rx_valid, err, busy;
    int          n_checks = 0, n_fail = 0, nv = 0, ne = 0, both = 0;
    logic        err_prev = 1'b0, busy_after_err = 1'b1;

    always #5 clk = ~clk;

    spi_slave_sync #(.DW(12), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
        .rx_valid(rx_valid), .err(err), .busy(busy)
    );

    always @(negedge clk) begin
        if (rx_valid === 1'b1) nv++;
        if (err === 1'b1) ne++;
        if (rx_valid === 1'b1 && err === 1'b1) both++;
        if (err_prev) busy_after_err = busy;
        err_prev = (err === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [11:0] d);
        tx_data = d;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
    endtask

    // The master drives mosi on each sclk fall and samples miso on each sclk rise. Each sclk phase lasts 6 clk.
    task automatic frame(input logic [11:0] w, input int n, output logic [11:0] rd);
        logic [11:0] v;
        v = '0;
        cs = 1'b0;
        mosi = w[0];
        wait_clk(6);
        for (int i = 0; i < n; i++) begin
            sclk = 1'b1;
            v[i] = miso;
            wait_clk(6);
            sclk = 1'b0;
            if (i + 1 < n) mosi = w[i+1];
            wait_clk(6);
        end
        cs = 1'b1;
        wait_clk(12);
        rd = v;
    endtask

    initial begin
        cs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 sclk = ~sclk;
        end
        @(negedge clk);
        check("rst_miso", miso, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        cs = 1'b1;
        sclk = 1'b0;
        wait_clk(10);
        check("idle_busy", busy, 0);

        load(12'h5A3);
        frame(12'hABC, 12, r);
        check("fd_miso", r, 12'h5A3);
        check("fd_rx_data", rx_data, 12'hABC);
        check("fd_nvalid", nv, 1);
        check("fd_nerr", ne, 0);

        frame(12'h0F0, 7, r);
        check("ab_miso", r, 12'h023);
        check("ab_nerr", ne, 1);
        check("ab_nvalid", nv, 1);
        check("ab_rx_data", rx_data, 12'hABC);
        check("ab_busy_after", busy_after_err, 0);
        check("ab_busy", busy, 0);

        load(12'h000);
        fork
            frame(12'h3C5, 12, r);
            begin
                wait_clk(40);
                load(12'hFFF);
            end
        join
        check("ld_cur_miso", r, 12'h000);
        check("ld_cur_rx", rx_data, 12'h3C5);
        frame(12'h0F0, 12, r);
        check("ld_next_miso", r, 12'hFFF);
        check("ld_next_rx", rx_data, 12'h0F0);
        check("ld_nvalid", nv, 3);

        fork
            frame(12'h7E5, 12, r);
            begin
                wait_clk(3);
                load(12'h801);
            end
        join
        check("byp_miso", r, 12'h801);
        check("byp_rx", rx_data, 12'h7E5);
        check("byp_nvalid", nv, 4);

        frame(12'h123, 12, r);
        check("b2b1_rx", rx_data, 12'h123);
        check("b2b1_miso", r, 12'h801);
        frame(12'h456, 12, r);
        check("b2b2_rx", rx_data, 12'h456);
        check("b2b2_miso", r, 12'h801);
        check("b2b_nvalid", nv, 6);
        check("b2b_nerr", ne, 1);
        check("no_overlap", both, 0);
        check("end_busy", busy, 0);
        check("end_miso", miso, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
